// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding imem reads,
// and a DEPTH-entry {pc, insn} FIFO drained by decode. A redirect flushes everything.
module fetch_queue #(
  parameter int              AWIDTH   = 32,
  parameter int              DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       imem_req_o,
  output logic [AWIDTH-1:0]          imem_addr_o,
  input  logic                       imem_rvalid_i,
  input  logic [DWIDTH-1:0]          imem_rdata_i,
  output logic                       insn_valid_o,
  input  logic                       insn_ready_i,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] req_pc;
  logic              busy;
  logic              drop;
  logic [CW-1:0]     rd_ptr;
  logic [CW-1:0]     wr_ptr;
  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];

  logic [CW-1:0]     count;
  logic [CW-1:0]     reserved;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic              unused_pc_bits;

  // Decode handshake: the head transfers on any cycle where insn_valid_o && insn_ready_i
  // (and no redirect); while valid is high and ready low the head is held unchanged.
  assign count    = wr_ptr - rd_ptr;
  assign reserved = count + CW'(busy);
  assign resp     = busy && imem_rvalid_i;

  // A new request is only issued when a FIFO slot is guaranteed for its response.
  assign issue = !redirect_i && !drop && (!busy || imem_rvalid_i) && (reserved < CW'(DEPTH));
  assign push  = resp && !drop && !redirect_i;
  assign pop   = insn_valid_o && insn_ready_i && !redirect_i;

  assign imem_req_o   = issue;
  assign imem_addr_o  = fetch_pc;
  assign insn_valid_o = (count != '0);
  assign insn_o       = insn_mem[rd_ptr[PW-1:0]];
  assign pc_o         = pc_mem[rd_ptr[PW-1:0]];
  assign count_o      = count;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= BASEADDR;
      req_pc   <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        insn_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      // An in-flight read whose data has not yet returned must be swallowed later.
      if (busy && !imem_rvalid_i) begin
        drop <= 1'b1;
      end else begin
        busy <= 1'b0;
        drop <= 1'b0;
      end
    end else begin
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + AWIDTH'(4);
        busy     <= 1'b1;
      end else if (resp) begin
        busy <= 1'b0;
      end
      if (resp && drop) begin
        drop <= 1'b0;
      end
      if (push) begin
        pc_mem[wr_ptr[PW-1:0]]   <= req_pc;
        insn_mem[wr_ptr[PW-1:0]] <= imem_rdata_i;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an imem model with programmable latency answers with the
// request address as data; a scoreboard holds the PCs decode is expected to see, in order.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        insn_valid_o;
  logic        insn_ready_i = 1'b1;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  fetch_queue #(
    .AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i),
    .insn_o(insn_o), .pc_o(pc_o), .count_o(count_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  bit hold = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  bit gap_chk = 0;
  int gap_exp = 1;
  int last_pop = -1;
  int n_pops = 0;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  bit          found;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_from(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  // One clock cycle: called just after a rising edge; drives imem, samples, then advances.
  task automatic cycle();
    logic [31:0] e;
    if (!hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend_addr.pop_front();
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hdead_beef;
    end
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = insn_valid_o;
    if (imem_req_o) begin
      check("one_outstanding", 32'(pend_due.size()), 32'd0);
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(cyc + lat);
    end
    if (insn_valid_o && insn_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", pc_o, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", pc_o, e);
        check("pop_insn", insn_o, e);
      end
      if (gap_chk && last_pop >= 0) check("pop_gap", 32'(cyc - last_pop), 32'(gap_exp));
      last_pop = cyc;
      n_pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and first fetches with 1-cycle imem
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(insn_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    rst = 1'b1;
    expect_from(BASE);
    gap_chk = 1; gap_exp = 1; last_pop = -1;
    cycle();
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, BASE);
    check("c0_valid", 32'(s_valid), 32'd0);
    cycle();
    check("c1_valid", 32'(s_valid), 32'd0);
    cycle();
    check("c2_valid", 32'(s_valid), 32'd1);
    repeat (8) cycle();

    // Backpressure fills the FIFO, then drains in order
    gap_chk = 0;
    insn_ready_i = 1'b0;
    repeat (6) cycle();
    check("full_count", 32'(count_o), 32'd4);
    cycle();
    check("full_noreq", 32'(s_req), 32'd0);
    check("full_valid", 32'(s_valid), 32'd1);
    check("head_stable", pc_o, exp_q[0]);
    insn_ready_i = 1'b1;
    repeat (10) cycle();

    // Redirect with 2 queued and a late response in flight
    insn_ready_i = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (count_o == 3'd2) found = 1;
      else cycle();
    end
    check("t3_reach2", 32'(found), 32'd1);
    hold = 1;
    cycle();
    check("t3_hold_noreq", 32'(s_req), 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0102;
    cycle();
    redirect_i = 1'b0;
    expect_from(32'h0100_0100);
    check("t3_count", 32'(count_o), 32'd0);
    check("t3_valid", 32'(insn_valid_o), 32'd0);
    hold = 0;
    cycle();
    check("t3_drop_block", 32'(s_req), 32'd0);
    cycle();
    check("t3_req", 32'(s_req), 32'd1);
    check("t3_addr", s_addr, 32'h0100_0100);
    insn_ready_i = 1'b1;
    repeat (8) cycle();

    // Redirect coinciding with a response and a pop
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0200_0010;
    cycle();
    check("t4_valid_at_redir", 32'(s_valid), 32'd1);
    check("t4_noreq_at_redir", 32'(s_req), 32'd0);
    redirect_i = 1'b0;
    expect_from(32'h0200_0010);
    check("t4_count", 32'(count_o), 32'd0);
    cycle();
    check("t4_req", 32'(s_req), 32'd1);
    check("t4_addr", s_addr, 32'h0200_0010);
    repeat (6) cycle();

    // Back-to-back redirects: last one wins
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0300_0000;
    cycle();
    redirect_pc_i = 32'h0300_0043;
    cycle();
    redirect_i = 1'b0;
    expect_from(32'h0300_0040);
    cycle();
    check("b2b_addr", s_addr, 32'h0300_0040);
    repeat (6) cycle();

    // 3-cycle imem latency: one insn every 3 cycles
    lat = 3;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0200;
    cycle();
    redirect_i = 1'b0;
    expect_from(32'h0100_0200);
    gap_chk = 1; gap_exp = 3; last_pop = -1; n_pops = 0;
    cycle();
    check("t5_addr", s_addr, 32'h0100_0200);
    repeat (23) cycle();
    check("t5_pops", 32'(n_pops), 32'd7);
    gap_chk = 0;

    // Asynchronous reset with 3 queued
    lat = 1;
    insn_ready_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (count_o == 3'd3) found = 1;
      else cycle();
    end
    check("t6_reach3", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(insn_valid_o), 32'd0);
    check("t6_count", 32'(count_o), 32'd0);
    imem_rvalid_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b1;
    insn_ready_i = 1'b1;
    expect_from(BASE);
    cycle();
    check("t6_req", 32'(s_req), 32'd1);
    check("t6_addr", s_addr, BASE);
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
